// File: rtl/acct_bank_arbiter.sv
// acct_bank_arbiter
// Owns the account table (password, balance and optional lock state per card)
// and shares its single access port between two requesters with round-robin
// arbitration. Each access is: IDLE (grant and latch inputs) -> ACCESS (table
// read or write, results registered) -> DONE (one-cycle ack on the granted port).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   rd_req/rd_card/rd_psw      card lookup + password check request
//   rd_ack/rd_err/rd_psw_ok/rd_locked/rd_balance   lookup results (held until next rd_ack)
//   wr_req/wr_card/wr_balance  balance write-back request
//   wr_ack/wr_err              write completion / rejection (held until next wr_ack)
//   busy                       FSM not in IDLE
//
// Optional feature macro: ACCT_LOCK_EN
//   defined   : per-entry fail counter; MAX_TRIES consecutive wrong passwords lock
//               the entry until reset (locked entries reject reads and writes).
//   undefined : no lock storage, rd_locked tied to 0.

module acct_bank_arbiter #(
    parameter int                         card_width     = 6,
    parameter int                         password_width = 16,
    parameter int                         balance_width  = 20,
    parameter int                         NUM_ACCOUNTS   = 48,
    parameter int                         INIT_BALANCE   = 1000,
    parameter logic [password_width-1:0]  PSW_DEFAULT    = 16'h1234,
    parameter int                         MAX_TRIES      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [card_width-1:0]      rd_card,
    input  logic [password_width-1:0]  rd_psw,
    output logic                       rd_ack,
    output logic                       rd_err,
    output logic                       rd_psw_ok,
    output logic                       rd_locked,
    output logic [balance_width-1:0]   rd_balance,
    input  logic                       wr_req,
    input  logic [card_width-1:0]      wr_card,
    input  logic [balance_width-1:0]   wr_balance,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic                       busy
);

    // Fail counter is 2 bits wide, so MAX_TRIES must fit in it.
    if (NUM_ACCOUNTS > (1 << card_width) || MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_cfg_err
        $error("acct_bank_arbiter: invalid NUM_ACCOUNTS/MAX_TRIES configuration");
    end

    localparam logic [card_width:0]    NUM_ACC_W  = NUM_ACCOUNTS[card_width:0];
    localparam logic [balance_width-1:0] INIT_BAL_W = INIT_BALANCE[balance_width-1:0];

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic       {PORT_RD, PORT_WR}   port_e;

    state_e                      state_q, state_d;
    port_e                       grant_q, grant_d;
    port_e                       last_q,  last_d;
    logic [card_width-1:0]       card_q,  card_d;
    logic [password_width-1:0]   psw_q,   psw_d;
    logic [balance_width-1:0]    bal_q,   bal_d;

    logic                        rd_err_q,    rd_err_d;
    logic                        rd_psw_ok_q, rd_psw_ok_d;
    logic                        rd_locked_q, rd_locked_d;
    logic [balance_width-1:0]    rd_balance_q, rd_balance_d;
    logic                        wr_err_q,    wr_err_d;

    logic [password_width-1:0]   psw_tab_q [0:NUM_ACCOUNTS-1];
    logic [balance_width-1:0]    bal_tab_q [0:NUM_ACCOUNTS-1];
`ifdef ACCT_LOCK_EN
    localparam logic [2:0]       MAX_T = MAX_TRIES[2:0];
    logic [1:0]                  fail_tab_q [0:NUM_ACCOUNTS-1];
    logic                        lock_tab_q [0:NUM_ACCOUNTS-1];
    logic [2:0]                  fail_inc;
`endif

    logic                        card_valid;
    logic                        psw_match;
    logic                        entry_locked;   // locked before this access
    logic                        lock_after;     // locked once this access completes
    logic [balance_width-1:0]    stored_bal;

    // Table lookup for the latched card
    always_comb begin
        card_valid   = ({1'b0, card_q} < NUM_ACC_W);
        psw_match    = 1'b0;
        stored_bal   = '0;
        entry_locked = 1'b0;
        lock_after   = 1'b0;
        if (card_valid) begin
            psw_match  = (psw_tab_q[card_q] == psw_q);
            stored_bal = bal_tab_q[card_q];
        end
`ifdef ACCT_LOCK_EN
        fail_inc = 3'd0;
        if (card_valid) begin
            fail_inc     = {1'b0, fail_tab_q[card_q]} + 3'd1;
            entry_locked = lock_tab_q[card_q];
            // A wrong password that exhausts the tries locks within the same
            // access, so that access already reports rd_locked=1.
            lock_after   = entry_locked | (!psw_match && (fail_inc >= MAX_T));
        end
`endif
    end

    // Next-state, grant and result logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        card_d       = card_q;
        psw_d        = psw_q;
        bal_d        = bal_q;
        rd_err_d     = rd_err_q;
        rd_psw_ok_d  = rd_psw_ok_q;
        rd_locked_d  = rd_locked_q;
        rd_balance_d = rd_balance_q;
        wr_err_d     = wr_err_q;

        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    // last_grant only moves on a tie; a lone request leaves it alone.
                    if (rd_req && wr_req) begin
                        grant_d = (last_q == PORT_WR) ? PORT_RD : PORT_WR;
                        last_d  = grant_d;
                    end else begin
                        grant_d = wr_req ? PORT_WR : PORT_RD;
                    end
                    card_d  = (grant_d == PORT_WR) ? wr_card : rd_card;
                    psw_d   = rd_psw;
                    bal_d   = wr_balance;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (grant_q == PORT_RD) begin
                    rd_err_d     = !card_valid;
                    rd_psw_ok_d  = card_valid && psw_match && !entry_locked;
                    rd_locked_d  = card_valid && lock_after;
                    rd_balance_d = rd_psw_ok_d ? stored_bal : '0;
                end else begin
                    wr_err_d     = !card_valid || entry_locked;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= PORT_RD;
            last_q       <= PORT_WR;
            card_q       <= '0;
            psw_q        <= '0;
            bal_q        <= '0;
            rd_err_q     <= 1'b0;
            rd_psw_ok_q  <= 1'b0;
            rd_locked_q  <= 1'b0;
            rd_balance_q <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            card_q       <= card_d;
            psw_q        <= psw_d;
            bal_q        <= bal_d;
            rd_err_q     <= rd_err_d;
            rd_psw_ok_q  <= rd_psw_ok_d;
            rd_locked_q  <= rd_locked_d;
            rd_balance_q <= rd_balance_d;
            wr_err_q     <= wr_err_d;
        end
    end

    // Account table: reset loads every entry, ACCESS performs the one update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
                psw_tab_q[i]  <= PSW_DEFAULT;
                bal_tab_q[i]  <= INIT_BAL_W;
`ifdef ACCT_LOCK_EN
                fail_tab_q[i] <= 2'd0;
                lock_tab_q[i] <= 1'b0;
`endif
            end
        end else if (state_q == ACCESS && card_valid && !entry_locked) begin
            if (grant_q == PORT_WR) begin
                bal_tab_q[card_q] <= bal_q;
            end
`ifdef ACCT_LOCK_EN
            else if (psw_match) begin
                fail_tab_q[card_q] <= 2'd0;
            end else begin
                fail_tab_q[card_q] <= fail_inc[1:0];
                if (lock_after) begin
                    lock_tab_q[card_q] <= 1'b1;
                end
            end
`endif
        end
    end

    assign rd_ack     = (state_q == DONE) && (grant_q == PORT_RD);
    assign wr_ack     = (state_q == DONE) && (grant_q == PORT_WR);
    assign busy       = (state_q != IDLE);
    assign rd_err     = rd_err_q;
    assign rd_psw_ok  = rd_psw_ok_q;
    assign rd_locked  = rd_locked_q;
    assign rd_balance = rd_balance_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_acct_bank_arbiter.sv
module tb_acct_bank_arbiter;

    localparam int CW   = 6;
    localparam int PW   = 16;
    localparam int BW   = 20;
    localparam int NACC = 48;
    localparam logic [PW-1:0] GOOD_PSW = 16'h1234;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_req = 1'b0;
    logic [CW-1:0] rd_card = '0;
    logic [PW-1:0] rd_psw = '0;
    logic          rd_ack, rd_err, rd_psw_ok, rd_locked;
    logic [BW-1:0] rd_balance;
    logic          wr_req = 1'b0;
    logic [CW-1:0] wr_card = '0;
    logic [BW-1:0] wr_balance = '0;
    logic          wr_ack, wr_err, busy;

    acct_bank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_card    (rd_card),
        .rd_psw     (rd_psw),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .rd_psw_ok  (rd_psw_ok),
        .rd_locked  (rd_locked),
        .rd_balance (rd_balance),
        .wr_req     (wr_req),
        .wr_card    (wr_card),
        .wr_balance (wr_balance),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    bit          rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   ack_cyc;
        logic          err;
        logic          ok;
        logic          lck;
        logic [BW-1:0] bal;
    } rd_exp_t;

    typedef struct {
        int unsigned ack_cyc;
        logic        err;
    } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];

    logic [BW-1:0] m_bal  [NACC];
    int            m_fail [NACC];
    bit            m_lock [NACC];
    bit            m_last_wr;

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) begin
            m_bal[i]  = BW'(1000);
            m_fail[i] = 0;
            m_lock[i] = 1'b0;
        end
        m_last_wr = 1'b1;
    endtask

    task automatic model_read(input logic [CW-1:0] card, input logic [PW-1:0] psw,
                              input int unsigned ac);
        rd_exp_t r;
        int      c;
        c = int'(card);
        r.ack_cyc = ac; r.err = 1'b0; r.ok = 1'b0; r.lck = 1'b0; r.bal = '0;
        if (c >= NACC) begin
            r.err = 1'b1;
        end else begin
`ifdef ACCT_LOCK_EN
            if (m_lock[c]) begin
                r.lck = 1'b1;
            end else if (psw == GOOD_PSW) begin
                m_fail[c] = 0;
                r.ok  = 1'b1;
                r.bal = m_bal[c];
            end else begin
                m_fail[c]++;
                if (m_fail[c] >= 3) m_lock[c] = 1'b1;
                r.lck = m_lock[c];
            end
`else
            if (psw == GOOD_PSW) begin
                r.ok  = 1'b1;
                r.bal = m_bal[c];
            end
`endif
        end
        rq.push_back(r);
    endtask

    task automatic model_write(input logic [CW-1:0] card, input logic [BW-1:0] val,
                               input int unsigned ac);
        wr_exp_t w;
        int      c;
        c = int'(card);
        w.ack_cyc = ac;
        w.err = (c >= NACC) || m_lock[c % NACC];
        if (!w.err) m_bal[c] = val;
        wq.push_back(w);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [BW+2:0] h_rd = '0;
    logic          h_wr = 1'b0;

    always @(negedge clk) begin
        if (!rst_s) begin
            chk("reset_acks",    {rd_ack, wr_ack, busy}, 0);
            chk("reset_rd_res",  {rd_err, rd_psw_ok, rd_locked, rd_balance}, 0);
            chk("reset_wr_err",  wr_err, 0);
            h_rd = '0;
            h_wr = 1'b0;
        end else begin
            if (rd_ack) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected_ack", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    chk("rd_ack_cycle", cyc, e.ack_cyc);
                    chk("rd_err",       rd_err,     e.err);
                    chk("rd_psw_ok",    rd_psw_ok,  e.ok);
                    chk("rd_locked",    rd_locked,  e.lck);
                    chk("rd_balance",   rd_balance, e.bal);
                    h_rd = {e.err, e.ok, e.lck, e.bal};
                end
            end else begin
                chk("rd_hold", {rd_err, rd_psw_ok, rd_locked, rd_balance}, h_rd);
            end
            if (wr_ack) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected_ack", 1, 0);
                end else begin
                    wr_exp_t w;
                    w = wq.pop_front();
                    chk("wr_ack_cycle", cyc, w.ack_cyc);
                    chk("wr_err",       wr_err, w.err);
                    h_wr = w.err;
                end
            end else begin
                chk("wr_hold", wr_err, h_wr);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic txn(input bit dr, input bit dw,
                       input logic [CW-1:0] rc, input logic [PW-1:0] rp,
                       input logic [CW-1:0] wc, input logic [BW-1:0] wb);
        int unsigned t0;
        bit          first_wr;
        bit          rd_pend, wr_pend;
        @(posedge clk); #1;
        chk("busy_when_idle", busy, 0);
        rd_req = dr; rd_card = rc; rd_psw = rp;
        wr_req = dw; wr_card = wc; wr_balance = wb;
        t0 = cyc;
        if (dr && dw) begin
            first_wr  = !m_last_wr;
            m_last_wr = first_wr;
            if (first_wr) begin
                model_write(wc, wb, t0 + 2);
                model_read(rc, rp, t0 + 5);
            end else begin
                model_read(rc, rp, t0 + 2);
                model_write(wc, wb, t0 + 5);
            end
        end else if (dr) begin
            model_read(rc, rp, t0 + 2);
        end else if (dw) begin
            model_write(wc, wb, t0 + 2);
        end
        rd_pend = dr;
        wr_pend = dw;
        for (int n = 0; n < 12 && (rd_pend || wr_pend); n++) begin
            @(posedge clk); #1;
            if (rd_pend && rd_ack) begin rd_pend = 1'b0; rd_req = 1'b0; end
            if (wr_pend && wr_ack) begin wr_pend = 1'b0; wr_req = 1'b0; end
        end
        if (rd_pend || wr_pend) begin
            chk("ack_timeout", 1, 0);
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] rc, wc;
        logic [PW-1:0] rp;
        bit            dr, dw;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // basic read, write then read-back
        txn(1, 0, 6'd5, GOOD_PSW, 6'd0, '0);
        txn(0, 1, 6'd0, '0, 6'd5, 20'd750);
        txn(1, 0, 6'd5, GOOD_PSW, 6'd0, '0);

        // simultaneous requests after reset: RD first, then WR first
        do_reset();
        txn(1, 1, 6'd7, GOOD_PSW, 6'd7, 20'd42);
        txn(1, 1, 6'd7, GOOD_PSW, 6'd7, 20'd99);

        // invalid cards
        txn(1, 0, 6'd50, GOOD_PSW, 6'd0, '0);
        txn(0, 1, 6'd0, '0, 6'd63, 20'd5);
        txn(1, 0, 6'd47, 16'h0001, 6'd0, '0);

        // wrong passwords on card 2, then correct password and a write
        for (int i = 0; i < 3; i++) txn(1, 0, 6'd2, 16'h0000, 6'd0, '0);
        txn(1, 0, 6'd2, GOOD_PSW, 6'd0, '0);
        txn(0, 1, 6'd0, '0, 6'd2, 20'd12345);
        txn(1, 0, 6'd2, GOOD_PSW, 6'd0, '0);

        // reset during the ACCESS cycle of a write
        @(posedge clk); #1;
        wr_req = 1'b1; wr_card = 6'd5; wr_balance = 20'd1;
        @(posedge clk); #1;
        chk("busy_in_access", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_reset", busy, 0);
        chk("no_wr_ack_after_reset", wr_ack, 0);
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        txn(1, 0, 6'd5, GOOD_PSW, 6'd0, '0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            dr = $urandom_range(0, 1);
            dw = $urandom_range(0, 1);
            if (!dr && !dw) dr = 1'b1;
            rc = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(48, 63)) : CW'($urandom_range(0, 11));
            wc = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(48, 63)) : CW'($urandom_range(0, 11));
            rp = ($urandom_range(0, 5) == 0) ? PW'($urandom) : GOOD_PSW;
            txn(dr, dw, rc, rp, wc, BW'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_drained", rq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
